// File: rtl/koa_seq_pkg.sv
// koa_seq_pkg: shared definitions for the sequential Karatsuba multiplier.
//   state_t  - 3-bit FSM state encoding used by koa_seq_ctrl
//   LATENCY  - rising edges from start acceptance to the ready_o cycle,
//              counting the accepting edge as the first
package koa_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    MUL_L   = 3'd1,
    MUL_R   = 3'd2,
    MUL_M   = 3'd3,
    COMBINE = 3'd4,
    DONE    = 3'd5
  } state_t;

  localparam int LATENCY = 5;

endpackage

// File: rtl/koa_seq_ctrl_mult.sv
// csubRecursiveKOA: combinational unsigned SW x SW multiplier. This is the
// only multiplier in the datapath; koa_seq_ctrl time-shares it over the
// three Karatsuba partial products.
//   Data_A_i, Data_B_i : SW-bit unsigned operands
//   Data_S_o           : 2*SW-bit product
module csubRecursiveKOA #(
  parameter int SW = 13
) (
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  output logic [2*SW-1:0] Data_S_o
);

  assign Data_S_o = {{SW{1'b0}}, Data_A_i} * {{SW{1'b0}}, Data_B_i};

endmodule

// File: rtl/koa_seq_ctrl.sv
// koa_seq_ctrl: one-level Karatsuba multiplier, sequenced over a single
// shared (H+1)x(H+1) multiplier. One result every 5 cycles when start_i
// is held high.
//   clk, rst_n : clock, synchronous active-low reset
//   start_i    : request; accepted only in IDLE or DONE
//   Data_A_i   : operand A, captured on acceptance
//   Data_B_i   : operand B, captured on acceptance
//   busy_o     : high in MUL_L, MUL_R, MUL_M, COMBINE
//   ready_o    : high for the single DONE cycle
//   Data_S_o   : registered product, held until the next COMBINE
module koa_seq_ctrl
  import koa_seq_pkg::*;
#(
  parameter int SW = 24
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start_i,
  input  logic [SW-1:0]   Data_A_i,
  input  logic [SW-1:0]   Data_B_i,
  output logic            busy_o,
  output logic            ready_o,
  output logic [2*SW-1:0] Data_S_o
);

  localparam int H = SW / 2;

  state_t state, state_nx;
  logic   accept;

  logic [SW-1:0]   a_q, b_q;
  logic [2*H-1:0]  q_l, q_r;
  logic [2*H+1:0]  q_m, s_b, prod;
  logic [H:0]      op_a, op_b;
  logic [2*SW-1:0] data_s, combine_sum;

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          accept   = 1'b1;
          state_nx = MUL_L;
        end
      end
      MUL_L:   state_nx = MUL_R;
      MUL_R:   state_nx = MUL_M;
      MUL_M:   state_nx = COMBINE;
      COMBINE: state_nx = DONE;
      DONE: begin
        // chaining straight from DONE gives the 5-cycle throughput
        if (start_i) begin
          accept   = 1'b1;
          state_nx = MUL_L;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // ---------------- shared multiplier operand mux ----------------
  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      MUL_L: begin
        op_a = {1'b0, a_q[SW-1:H]};
        op_b = {1'b0, b_q[SW-1:H]};
      end
      MUL_R: begin
        op_a = {1'b0, a_q[H-1:0]};
        op_b = {1'b0, b_q[H-1:0]};
      end
      MUL_M: begin
        // half sums need the extra bit; this is why the multiplier is H+1 wide
        op_a = {1'b0, a_q[SW-1:H]} + {1'b0, a_q[H-1:0]};
        op_b = {1'b0, b_q[SW-1:H]} + {1'b0, b_q[H-1:0]};
      end
      default: ;
    endcase
  end

  csubRecursiveKOA #(.SW(H + 1)) u_mult (
    .Data_A_i (op_a),
    .Data_B_i (op_b),
    .Data_S_o (prod)
  );

  // middle term Ah*Bl + Al*Bh; Q_m >= Q_l + Q_r so this never underflows
  assign s_b = q_m - {2'b00, q_l} - {2'b00, q_r};
  assign combine_sum = {q_l, q_r} + ({{(SW-2){1'b0}}, s_b} << H);

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      q_l    <= '0;
      q_r    <= '0;
      q_m    <= '0;
      data_s <= '0;
    end else begin
      if (accept) begin
        a_q <= Data_A_i;
        b_q <= Data_B_i;
      end
      case (state)
        MUL_L:   q_l    <= prod[2*H-1:0];
        MUL_R:   q_r    <= prod[2*H-1:0];
        MUL_M:   q_m    <= prod;
        COMBINE: data_s <= combine_sum;
        default: ;
      endcase
    end
  end

  assign busy_o   = (state == MUL_L) || (state == MUL_R) ||
                    (state == MUL_M) || (state == COMBINE);
  assign ready_o  = (state == DONE);
  assign Data_S_o = data_s;

endmodule

// File: tb/tb_koa_seq_ctrl.sv
// tb_koa_seq_ctrl: scoreboard bench for koa_seq_ctrl at SW=24 and SW=8.
// Drivers push the golden product A*B when an operation is issued; a
// monitor per instance pops and compares whenever ready_o is seen.
module tb_koa_seq_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n   = 1'b0;
  logic        start24 = 1'b0;
  logic [23:0] a24 = '0, b24 = '0;
  logic        busy24, ready24;
  logic [47:0] s24;

  logic        start8 = 1'b0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, ready8;
  logic [15:0] s8;

  int tests = 0;
  int fails = 0;

  logic [47:0] q24[$];
  logic [15:0] q8[$];

  koa_seq_ctrl #(.SW(24)) dut24 (
    .clk(clk), .rst_n(rst_n), .start_i(start24),
    .Data_A_i(a24), .Data_B_i(b24),
    .busy_o(busy24), .ready_o(ready24), .Data_S_o(s24)
  );

  koa_seq_ctrl #(.SW(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8),
    .Data_A_i(a8), .Data_B_i(b8),
    .busy_o(busy8), .ready_o(ready8), .Data_S_o(s8)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    logic [47:0] e;
    if (ready24) begin
      if (q24.size() == 0) begin
        tests++; fails++;
        $display("FAIL s24_unexpected_ready: got ready with data %0h expected no pulse", s24);
      end else begin
        e = q24.pop_front();
        chk("s24_product", s24, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [15:0] e;
    if (ready8) begin
      if (q8.size() == 0) begin
        tests++; fails++;
        $display("FAIL s8_unexpected_ready: got ready with data %0h expected no pulse", s8);
      end else begin
        e = q8.pop_front();
        chk("s8_product", s8, e);
      end
    end
  end

  // ---------------- helpers ----------------
  function automatic logic [23:0] pick24();
    case ($urandom_range(0, 7))
      0:       return 24'h0;
      1:       return 24'hFFFFFF;
      default: return 24'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] pick8();
    case ($urandom_range(0, 7))
      0:       return 8'h0;
      1:       return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  // One timed op on the 24-bit instance. With poke set, a second start
  // (7*7) is pulsed while busy and must be ignored.
  task automatic op24(input logic [23:0] a, input logic [23:0] b, input bit poke);
    @(negedge clk);
    start24 = 1'b1; a24 = a; b24 = b;
    q24.push_back({24'b0, a} * {24'b0, b});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin
        start24 = poke;
        if (poke) begin a24 = 24'd7; b24 = 24'd7; end
      end
      if (k == 2) start24 = 1'b0;
      chk("op24_busy", busy24, 1);
      chk("op24_ready_low", ready24, 0);
    end
    @(negedge clk);
    chk("op24_ready_at5", ready24, 1);
    chk("op24_busy_done", busy24, 0);
  endtask

  task automatic rnd24(input int n);
    logic [23:0] a, b;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      a = pick24(); b = pick24();
      start24 = 1'b1; a24 = a; b24 = b;
      q24.push_back({24'b0, a} * {24'b0, b});
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        chk("rnd24_busy", busy24, 1);
        start24 = 1'($urandom_range(0, 1));
        a24 = 24'($urandom); b24 = 24'($urandom);
      end
      @(negedge clk);
      chk("rnd24_ready", ready24, 1);
      if ($urandom_range(0, 3) == 0) begin
        start24 = 1'b0;
        @(negedge clk);
      end
    end
    start24 = 1'b0;
  endtask

  task automatic rnd8(input int n);
    logic [7:0] a, b;
    @(negedge clk);
    for (int i = 0; i < n; i++) begin
      a = pick8(); b = pick8();
      start8 = 1'b1; a8 = a; b8 = b;
      q8.push_back({8'b0, a} * {8'b0, b});
      for (int k = 1; k <= 4; k++) begin
        @(negedge clk);
        chk("rnd8_busy", busy8, 1);
        start8 = 1'($urandom_range(0, 1));
        a8 = 8'($urandom); b8 = 8'($urandom);
      end
      @(negedge clk);
      chk("rnd8_ready", ready8, 1);
      if ($urandom_range(0, 3) == 0) begin
        start8 = 1'b0;
        @(negedge clk);
      end
    end
    start8 = 1'b0;
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst_n = 1'b0;
    start24 = 1'b1;            // must be ignored under reset
    repeat (2) @(negedge clk);
    chk("reset_busy", busy24, 0);
    chk("reset_ready", ready24, 0);
    chk("reset_data", s24, 0);
    chk("reset_busy8", busy8, 0);
    start24 = 1'b0;
    rst_n = 1'b1;

    // all ones
    op24(24'hFFFFFF, 24'hFFFFFF, 1'b0);
    chk("allones_data", s24, 48'hFFFFFE000001);
    @(negedge clk);
    chk("allones_single_pulse", ready24, 0);

    // zero operand
    op24(24'h0, 24'hABCDEF, 1'b0);
    chk("zero_data", s24, 0);

    // start while busy is ignored
    op24(24'd3, 24'd5, 1'b1);
    chk("busy_start_data", s24, 15);
    repeat (6) begin
      @(negedge clk);
      chk("busy_start_no_extra", ready24, 0);
    end

    // back-to-back with start held high
    @(negedge clk);
    start24 = 1'b1; a24 = 24'd2; b24 = 24'd3;
    q24.push_back(48'd6);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) begin a24 = 24'h800000; b24 = 24'd2; end
      chk("b2b_busy1", busy24, 1);
    end
    @(negedge clk);
    chk("b2b_ready1", ready24, 1);
    chk("b2b_data1", s24, 48'd6);
    q24.push_back({24'b0, a24} * {24'b0, b24});
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) start24 = 1'b0;
      chk("b2b_gap_ready", ready24, 0);
      chk("b2b_hold", s24, 48'd6);
    end
    @(negedge clk);
    chk("b2b_ready2", ready24, 1);
    chk("b2b_data2", s24, 48'h1000000);

    // reset mid-operation: discarded, no pulse
    @(negedge clk);
    start24 = 1'b1; a24 = 24'h123456; b24 = 24'h654321;
    @(negedge clk);
    start24 = 1'b0;
    @(negedge clk);
    rst_n = 1'b0; start24 = 1'b1; a24 = 24'd9; b24 = 24'd9;
    @(negedge clk);
    chk("midrst_data", s24, 0);
    chk("midrst_busy", busy24, 0);
    chk("midrst_ready", ready24, 0);
    rst_n = 1'b1; start24 = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("midrst_quiet_busy", busy24, 0);
      chk("midrst_quiet_ready", ready24, 0);
    end
    op24(24'h123456, 24'h654321, 1'b0);
    chk("midrst_fresh", s24, 48'h123456 * 48'h654321);

    // random, both widths concurrently
    fork
      rnd24(10000);
      rnd8(10000);
    join

    repeat (10) @(negedge clk);
    chk("q24_drained", q24.size(), 0);
    chk("q8_drained", q8.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/koa_seq_ctrl.md
KOA_SEQ_CTRL -- requirements
Module: koa_seq_ctrl

Interface
REQ-001 SHALL have parameter SW, default 24, meaning operand width in bits; legal values are even and at least 8.
REQ-002 SHALL have localparam H = SW/2, meaning the half-operand width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port start_i, input, 1 bit: requests a multiply; sampled on the rising edge.
REQ-006 SHALL have port Data_A_i, input, SW bits: unsigned operand A; sampled only when start is accepted.
REQ-007 SHALL have port Data_B_i, input, SW bits: unsigned operand B; sampled only when start is accepted.
REQ-008 SHALL have port busy_o, output, 1 bit: high while an operation is in progress.
REQ-009 SHALL have port ready_o, output, 1 bit: one-cycle pulse marking a valid new result.
REQ-010 SHALL have port Data_S_o, output, 2*SW bits: registered product A*B.

Function
REQ-011 SHALL compute A*B by one Karatsuba level, time-multiplexed over a single shared (H+1)x(H+1) combinational multiplier.
REQ-012 SHALL implement the FSM states IDLE, MUL_L, MUL_R, MUL_M, COMBINE and DONE.
REQ-013 SHALL accept start_i only in IDLE or DONE; on acceptance it registers A and B and moves to MUL_L.
REQ-014 SHALL, in MUL_L, multiply zero-extended A[SW-1:H] by B[SW-1:H], register the low 2H bits as Q_l, and move to MUL_R.
REQ-015 SHALL, in MUL_R, multiply zero-extended A[H-1:0] by B[H-1:0], register the low 2H bits as Q_r, and move to MUL_M.
REQ-016 SHALL, in MUL_M, multiply (A_hi+A_lo) by (B_hi+B_lo), each sum H+1 bits, register the 2H+2-bit result as Q_m, and move to COMBINE.
REQ-017 SHALL, in COMBINE, compute S_B = Q_m - Q_l - Q_r (2H+2 bits, never negative), register Data_S_o = {Q_l,Q_r} + (S_B << H) truncated to 2*SW bits, and move to DONE.
REQ-018 SHALL hold ready_o high for exactly the DONE cycle; DONE moves to IDLE, or to MUL_L if start_i is high in DONE.
REQ-019 SHALL set busy_o = 1 in MUL_L, MUL_R, MUL_M and COMBINE, and 0 in IDLE and DONE.
REQ-020 SHALL have a latency of 5 rising edges from the edge that accepts start to the first cycle in which ready_o = 1 and Data_S_o is valid.
REQ-021 SHALL ignore start_i while busy_o = 1; the in-flight operation and its operands stay unchanged.
REQ-022 SHALL hold Data_S_o stable from DONE until the next COMBINE edge, including during a following operation.
REQ-023 SHALL give a throughput of one result per 5 cycles when start_i is held high continuously.

Reset
REQ-024 SHALL, when rst_n = 0 at a rising edge, set the state to IDLE, busy_o = 0, ready_o = 0, Data_S_o = 0, and clear all operand and partial-product registers.
REQ-025 SHALL abort and discard any operation in flight when reset is asserted mid-operation, with no ready_o pulse for it.
REQ-026 SHALL ignore start_i on any edge where rst_n = 0.

Structure
REQ-027 SHALL place the FSM state encoding (3-bit) and the LATENCY=5 constant in a shared package, koa_seq_pkg.
REQ-028 SHALL instantiate exactly one multiplier sub-module, csubRecursiveKOA with SW = H+1; its operand muxing is selected by the FSM state.
REQ-029 SHALL contain no other arithmetic multipliers.

Verification
REQ-030 SHALL cover the all-ones case: SW=24, A=B=0xFFFFFF, start pulsed once -> ready_o at edge 5 with Data_S_o = 0xFFFFFE000001, and busy_o high for edges 1-4.
REQ-031 SHALL cover a zero operand: A=0, B=0xABCDEF -> Data_S_o = 0 with a single ready_o pulse.
REQ-032 SHALL cover start while busy: A=3, B=5 started, then start_i pulsed at edge 2 with A=7, B=7 -> exactly one ready_o pulse, and Data_S_o = 15.
REQ-033 SHALL cover back-to-back operation: start_i held high with A=2, B=3 and then A=0x800000, B=2 -> results 6 then 0x1000000, with ready_o pulses 5 cycles apart.
REQ-034 SHALL cover reset mid-operation: start, then rst_n=0 at edge 3 -> Data_S_o = 0, busy_o = 0 and no ready_o; a fresh start then completes correctly.
REQ-035 SHALL cover random stimulus: 10,000 random operand pairs for SW=24 and SW=8, each compared against the golden product A*B.
